// File: rtl/gp_pkg.sv
// Shared graphics-processor definitions: frame-buffer geometry, DRAM command codes,
// fill FSM states and the burst address helper shared with the line engine.
package gp_pkg;

  localparam int unsigned FB_WIDTH      = 800;
  localparam int unsigned FB_HEIGHT     = 600;
  localparam int unsigned FB_ROW_STRIDE = 1024;

  localparam int unsigned CNT_W       = $clog2(FB_ROW_STRIDE);
  localparam int unsigned XBLK_W      = CNT_W - 3;
  localparam int unsigned FRAME_SEL_W = 6;
  localparam int unsigned ADDR_W      = 31;
  localparam int unsigned CMD_W       = 3;
  localparam int unsigned COLOR_W     = 24;
  localparam int unsigned FRAME_W     = 32;
  localparam int unsigned DATA_W      = 128;
  localparam int unsigned MASK_W      = 16;

  localparam logic [CMD_W-1:0] AF_CMD_WRITE = 3'b000;

  typedef enum logic [1:0] {
    FF_IDLE = 2'd0,
    FF_W1   = 2'd1,
    FF_W2   = 2'd2
  } ff_state_e;

  // x_blk is the pixel column divided by 8 (one 8-pixel burst per step)
  function automatic logic [ADDR_W-1:0] fb_burst_addr(
    input logic [FRAME_SEL_W-1:0] frame_sel,
    input logic [XBLK_W-1:0]      x_blk,
    input logic [CNT_W-1:0]       y
  );
    return {6'b0, frame_sel, y, x_blk, 2'b00};
  endfunction

endpackage

// File: rtl/frame_filler_fill_addr_gen.sv
// Raster x/y burst counters for the frame fill; produces the current burst address
// and flags the final burst of the frame.
module fill_addr_gen
  import gp_pkg::*;
#(
  parameter int unsigned WIDTH  = FB_WIDTH,
  parameter int unsigned HEIGHT = FB_HEIGHT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step,
  input  logic                   clear,
  input  logic [FRAME_SEL_W-1:0] frame_sel,
  output logic                   last,
  output logic [ADDR_W-1:0]      addr
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(WIDTH - 8);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(HEIGHT - 1);

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;

  // x steps by one burst; wrapping x advances y
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (step) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(8);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign last = (x_q == X_LAST) && (y_q == Y_LAST);
  assign addr = fb_burst_addr(frame_sel, x_q[CNT_W-1:3], y_q);

endmodule

// File: rtl/frame_filler.sv
// Fills a whole frame buffer with one colour: two 128-bit write beats and one
// address entry per 8-pixel burst, pushed into the DRAM request controller FIFOs.
module frame_filler
  import gp_pkg::*;
#(
  parameter int unsigned WIDTH  = FB_WIDTH,
  parameter int unsigned HEIGHT = FB_HEIGHT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [COLOR_W-1:0] color,
  input  logic [FRAME_W-1:0] frame,
  output logic               ready,
  input  logic               af_full,
  input  logic               wdf_full,
  output logic               af_wr_en,
  output logic [CMD_W-1:0]   af_cmd_din,
  output logic [ADDR_W-1:0]  af_addr_din,
  output logic               wdf_wr_en,
  output logic [DATA_W-1:0]  wdf_din,
  output logic [MASK_W-1:0]  wdf_mask_din
);

  ff_state_e              state_q, state_d;
  logic [COLOR_W-1:0]     color_q, color_d;
  logic [FRAME_SEL_W-1:0] frame_q, frame_d;
  logic                   gen_step;
  logic                   gen_clear;
  logic                   gen_last;
  logic                   unused_frame_c;

  // only the frame-select field of the base is meaningful to the address map
  assign unused_frame_c = ^{frame[31:28], frame[21:0]};

  fill_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .step      (gen_step),
    .clear     (gen_clear),
    .frame_sel (frame_q),
    .last      (gen_last),
    .addr      (af_addr_din)
  );

  // next state and FIFO enables; W1 pushes the address and beat 0 together or not at all
  always_comb begin
    state_d   = state_q;
    color_d   = color_q;
    frame_d   = frame_q;
    gen_step  = 1'b0;
    gen_clear = 1'b0;
    ready     = 1'b0;
    af_wr_en  = 1'b0;
    wdf_wr_en = 1'b0;
    case (state_q)
      FF_IDLE: begin
        ready = 1'b1;
        if (valid) begin
          color_d   = color;
          frame_d   = frame[27:22];
          gen_clear = 1'b1;
          state_d   = FF_W1;
        end
      end
      FF_W1: begin
        if (!af_full && !wdf_full) begin
          af_wr_en  = 1'b1;
          wdf_wr_en = 1'b1;
          state_d   = FF_W2;
        end
      end
      FF_W2: begin
        if (!wdf_full) begin
          wdf_wr_en = 1'b1;
          if (gen_last) begin
            state_d = FF_IDLE;
          end else begin
            gen_step = 1'b1;
            state_d  = FF_W1;
          end
        end
      end
      default: state_d = FF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FF_IDLE;
      color_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      frame_q <= frame_d;
    end
  end

  assign af_cmd_din   = AF_CMD_WRITE;
  assign wdf_din      = {4{8'h00, color_q}};
  assign wdf_mask_din = '0;

endmodule

// File: tb/tb_frame_filler.sv
// Directed bench for frame_filler: a 16x2 instance for fill, backpressure, busy and
// reset cases, and an 800x4 instance for full-width row wrap and the last address.
module tb_frame_filler;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_s, valid_w;
  logic [23:0]  color;
  logic [31:0]  frame;
  logic         af_full, wdf_full;

  logic         s_ready, s_af_wr_en, s_wdf_wr_en;
  logic [2:0]   s_af_cmd_din;
  logic [30:0]  s_af_addr_din;
  logic [127:0] s_wdf_din;
  logic [15:0]  s_wdf_mask_din;

  logic         w_ready, w_af_wr_en, w_wdf_wr_en;
  logic [2:0]   w_af_cmd_din;
  logic [30:0]  w_af_addr_din;
  logic [127:0] w_wdf_din;
  logic [15:0]  w_wdf_mask_din;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  int viol    = 0;
  int bad_cm  = 0;
  int w_bad   = 0;
  int lat;

  logic [30:0]  s_addr_q[$];
  logic [127:0] s_data_q[$];
  logic [30:0]  w_addr_q[$];
  int           w_beats = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_filler #(.WIDTH(16), .HEIGHT(2)) u_small (
    .clk(clk), .rst(rst), .valid(valid_s), .color(color), .frame(frame),
    .ready(s_ready), .af_full(af_full), .wdf_full(wdf_full),
    .af_wr_en(s_af_wr_en), .af_cmd_din(s_af_cmd_din), .af_addr_din(s_af_addr_din),
    .wdf_wr_en(s_wdf_wr_en), .wdf_din(s_wdf_din), .wdf_mask_din(s_wdf_mask_din)
  );

  frame_filler #(.WIDTH(800), .HEIGHT(4)) u_wide (
    .clk(clk), .rst(rst), .valid(valid_w), .color(color), .frame(frame),
    .ready(w_ready), .af_full(1'b0), .wdf_full(1'b0),
    .af_wr_en(w_af_wr_en), .af_cmd_din(w_af_cmd_din), .af_addr_din(w_af_addr_din),
    .wdf_wr_en(w_wdf_wr_en), .wdf_din(w_wdf_din), .wdf_mask_din(w_wdf_mask_din)
  );

  // push monitors, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (s_af_wr_en) begin
        s_addr_q.push_back(s_af_addr_din);
        if (af_full) viol++;
        if (s_af_cmd_din != 3'b000) bad_cm++;
      end
      if (s_wdf_wr_en) begin
        s_data_q.push_back(s_wdf_din);
        if (wdf_full) viol++;
        if (s_wdf_mask_din != 16'h0000) bad_cm++;
      end
      if (w_af_wr_en) w_addr_q.push_back(w_af_addr_din);
      if (w_wdf_wr_en) begin
        w_beats++;
        if (w_wdf_din != {4{32'h0012_3456}}) w_bad++;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic do_accept(input bit wide, input logic [23:0] c, input logic [31:0] f);
    @(posedge clk); #1;
    color = c;
    frame = f;
    if (wide) valid_w = 1'b1; else valid_s = 1'b1;
    @(posedge clk); #1;
    valid_s = 1'b0;
    valid_w = 1'b0;
    t0 = cyc;
  endtask

  // latency in cycles from the accept cycle to the first cycle with ready high
  task automatic wait_ready(input bit wide, input int bound, output int l);
    l = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((wide ? w_ready : s_ready) == 1'b1) begin
        l = cyc - t0 + 1;
        break;
      end
    end
    if (l < 0) chk("ready_timeout", wide ? w_ready : s_ready, 1'b1);
  endtask

  // one 16x2 fill: four bursts at base + {y=0/1, xblk=0/1}, eight identical beats
  task automatic chk_fill(input string tag, input int ia, input int id,
                          input logic [30:0] base, input logic [127:0] beat);
    logic [30:0] offs [4];
    offs = '{31'h000, 31'h004, 31'h200, 31'h204};
    for (int i = 0; i < 4; i++) chk({tag, "_addr"}, s_addr_q[ia + i], base + offs[i]);
    for (int i = 0; i < 8; i++) chk({tag, "_data"}, s_data_q[id + i], beat);
  endtask

  task automatic clear_mon();
    s_addr_q.delete();
    s_data_q.delete();
    viol = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid_s = 1'b0; valid_w = 1'b0;
    color = '0; frame = '0; af_full = 1'b0; wdf_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_af_en", s_af_wr_en, 1'b0);
    chk("rst_wdf_en", s_wdf_wr_en, 1'b0);
    chk("rst_addr", s_af_addr_din, 31'h0);
    chk("rst_data", s_wdf_din, 128'h0);
    chk("rst_w_ready", w_ready, 1'b1);

    // small fill; frame 0x1040_0000 selects 1 -> field at bit 19
    clear_mon();
    do_accept(1'b0, 24'hFF8000, 32'h1040_0000);
    wait_ready(1'b0, 100, lat);
    chk("fill_lat", lat, 9);
    chk("fill_af_n", s_addr_q.size(), 4);
    chk("fill_wdf_n", s_data_q.size(), 8);
    chk_fill("fill", 0, 0, 31'h0008_0000, {4{32'h00FF_8000}});

    // backpressure: af_full for 5 W1 cycles, then wdf_full for 3 W2 cycles
    clear_mon();
    do_accept(1'b0, 24'hFF8000, 32'h1040_0000);
    af_full = 1'b1;
    repeat (5) @(posedge clk);
    #1 af_full = 1'b0;
    chk("bp_af_stall", s_addr_q.size() + s_data_q.size(), 0);
    @(posedge clk);
    #1 wdf_full = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_wdf_stall", s_data_q.size(), 1);
    wdf_full = 1'b0;
    wait_ready(1'b0, 100, lat);
    chk("bp_lat", lat, 17);
    chk("bp_viol", viol, 0);
    chk("bp_af_n", s_addr_q.size(), 4);
    chk("bp_wdf_n", s_data_q.size(), 8);
    chk_fill("bp", 0, 0, 31'h0008_0000, {4{32'h00FF_8000}});

    // valid held while busy: ignored, then accepted the cycle ready rises
    clear_mon();
    do_accept(1'b0, 24'hFF8000, 32'h1040_0000);
    repeat (3) @(posedge clk);
    #1;
    color = 24'h00FF00;
    frame = 32'h0;
    valid_s = 1'b1;
    wait_ready(1'b0, 100, lat);
    chk("busy_lat", lat, 9);
    chk("busy_af_n", s_addr_q.size(), 4);
    @(posedge clk); #1;
    valid_s = 1'b0;
    t0 = cyc;
    @(negedge clk);
    chk("rehold_busy", s_ready, 1'b0);
    wait_ready(1'b0, 100, lat);
    chk("rehold_lat", lat, 9);
    chk("rehold_af_n", s_addr_q.size(), 8);
    chk("rehold_wdf_n", s_data_q.size(), 16);
    chk_fill("busy", 0, 0, 31'h0008_0000, {4{32'h00FF_8000}});
    chk_fill("rehold", 4, 8, 31'h0000_0000, {4{32'h0000_FF00}});

    // reset after three bursts, then a fresh fill with the top frame select
    clear_mon();
    do_accept(1'b0, 24'hABCDEF, 32'h1040_0000);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", s_ready, 1'b1);
    chk("rstmid_af_en", s_af_wr_en, 1'b0);
    chk("rstmid_wdf_en", s_wdf_wr_en, 1'b0);
    chk("rstmid_af_n", s_addr_q.size(), 3);
    clear_mon();
    do_accept(1'b0, 24'h0000AA, 32'hFFC0_0000);
    wait_ready(1'b0, 100, lat);
    chk("restart_lat", lat, 9);
    chk("restart_af_n", s_addr_q.size(), 4);
    chk_fill("restart", 0, 0, 31'h01F8_0000, {4{32'h0000_00AA}});
    chk("cmd_mask", bad_cm, 0);

    // 800 wide: 100 bursts per row, 4 rows
    w_addr_q.delete();
    w_beats = 0;
    w_bad = 0;
    do_accept(1'b1, 24'h123456, 32'h1040_0000);
    wait_ready(1'b1, 2000, lat);
    chk("wide_lat", lat, 801);
    chk("wide_af_n", w_addr_q.size(), 400);
    chk("wide_wdf_n", w_beats, 800);
    chk("wide_data", w_bad, 0);
    chk("wide_first", w_addr_q[0], 31'h0008_0000);
    chk("wide_row_end", w_addr_q[99], 31'h0008_018C);
    chk("wide_row_wrap", w_addr_q[100], 31'h0008_0200);
    chk("wide_last", w_addr_q[399], 31'h0008_078C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
